// File: rtl/mask_pixel_engine.sv
`default_nettype none
// ============================================================================
// mask_pixel_engine : 3x3 RGB444 neighbourhood filter over a raster pixel stream
// Revision: 1.0
// ============================================================================
module mask_pixel_engine #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pix_in,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [1:0]  mask_sel,
  output logic [11:0] mask_pixel_result,
  output logic [7:0]  mask_pixel_row_out,
  output logic [8:0]  mask_pixel_col_out,
  output logic        mask_pixel_valid,
  output logic        frame_done,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  localparam int         AW             = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [8:0] C_LAST_COL     = 9'(IMG_W - 1);
  localparam logic [7:0] C_LAST_ROW     = 8'(IMG_H - 1);
  localparam logic [8:0] C_OUT_LAST_COL = 9'(IMG_W - 2);
  localparam logic [7:0] C_OUT_LAST_ROW = 8'(IMG_H - 2);

  state_t      state_q;
  logic [8:0]  col_q;
  logic [7:0]  row_q;
  logic [1:0]  mode_q;
  logic        busy_q;
  logic [11:0] lb0_q [IMG_W];
  logic [11:0] lb1_q [IMG_W];
  logic [11:0] win_q [3][3];
  logic        s1_valid_q;
  logic [7:0]  s1_row_q;
  logic [8:0]  s1_col_q;
  logic [11:0] res_q;
  logic [7:0]  row_out_q;
  logic [8:0]  col_out_q;
  logic        valid_q;
  logic        done_q;

  logic          accept, sof_acc, abort, last_pix, fd_d;
  logic [8:0]    pos_col;
  logic [7:0]    pos_row;
  logic [AW-1:0] lb_addr;
  logic [11:0]   filt_d;

  assign accept   = pix_valid && (pix_sof || state_q == S_FILL || state_q == S_RUN);
  assign sof_acc  = accept && pix_sof;
  assign abort    = sof_acc && (state_q == S_FILL || state_q == S_RUN);
  assign pos_col  = pix_sof ? 9'd0 : col_q;
  assign pos_row  = pix_sof ? 8'd0 : row_q;
  assign lb_addr  = pos_col[AW-1:0];
  assign last_pix = (pos_row == C_LAST_ROW) && (pos_col == C_LAST_COL);
  assign fd_d     = valid_q && (row_out_q == C_OUT_LAST_ROW) && (col_out_q == C_OUT_LAST_COL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (pos_col == C_LAST_COL) begin
          col_q <= '0;
          row_q <= (pos_row == C_LAST_ROW) ? 8'd0 : pos_row + 8'd1;
        end else begin
          col_q <= pos_col + 9'd1;
          row_q <= pos_row;
        end
      end
      if (sof_acc) mode_q <= mask_sel;
      if (sof_acc)   busy_q <= 1'b1;
      else if (fd_d) busy_q <= 1'b0;
      case (state_q)
        S_IDLE:  if (sof_acc) state_q <= S_FILL;
        S_FILL:  if (accept && !pix_sof && pos_row == 8'd1 && pos_col == C_LAST_COL) state_q <= S_RUN;
        S_RUN: begin
          if (sof_acc)                  state_q <= S_FILL;
          else if (accept && last_pix)  state_q <= S_DONE;
        end
        S_DONE:  state_q <= sof_acc ? S_FILL : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line buffers feed the two older window rows; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[lb_addr] <= pix_in;
      lb1_q[lb_addr] <= lb0_q[lb_addr];
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2] <= lb1_q[lb_addr];
      win_q[1][2] <= lb0_q[lb_addr];
      win_q[2][2] <= pix_in;
    end
  end

  function automatic logic [3:0] filt4(input logic [1:0] m,
      input logic [3:0] p00, input logic [3:0] p01, input logic [3:0] p02,
      input logic [3:0] p10, input logic [3:0] p11, input logic [3:0] p12,
      input logic [3:0] p20, input logic [3:0] p21, input logic [3:0] p22);
    logic [7:0]        sum;
    logic signed [7:0] sh;
    logic [3:0]        res;
    sum = 8'(p00) + 8'(p02) + 8'(p20) + 8'(p22)
        + {3'b0, p01, 1'b0} + {3'b0, p10, 1'b0} + {3'b0, p12, 1'b0} + {3'b0, p21, 1'b0}
        + {2'b0, p11, 2'b0};
    sh  = 8'sd5 * $signed({4'b0, p11}) - $signed({4'b0, p01}) - $signed({4'b0, p21})
        - $signed({4'b0, p10}) - $signed({4'b0, p12});
    case (m)
      2'd0:    res = p11;
      2'd1:    res = sum[7:4];
      2'd2:    res = sh[7] ? 4'd0 : ((sh > 8'sd15) ? 4'd15 : sh[3:0]);
      default: res = 4'd15 - p11;
    endcase
    return res;
  endfunction

  always_comb begin
    filt_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      filt_d[ch*4 +: 4] = filt4(mode_q,
        win_q[0][0][ch*4 +: 4], win_q[0][1][ch*4 +: 4], win_q[0][2][ch*4 +: 4],
        win_q[1][0][ch*4 +: 4], win_q[1][1][ch*4 +: 4], win_q[1][2][ch*4 +: 4],
        win_q[2][0][ch*4 +: 4], win_q[2][1][ch*4 +: 4], win_q[2][2][ch*4 +: 4]);
    end
  end

  // An aborting SOF kills the old-frame pixel still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      res_q      <= '0;
      row_out_q  <= '0;
      col_out_q  <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      s1_valid_q <= accept && (pos_row >= 8'd2) && (pos_col >= 9'd2);
      s1_row_q   <= pos_row - 8'd1;
      s1_col_q   <= pos_col - 9'd1;
      done_q     <= fd_d;
      if (s1_valid_q && !abort) begin
        res_q     <= filt_d;
        row_out_q <= s1_row_q;
        col_out_q <= s1_col_q;
        valid_q   <= 1'b1;
      end else begin
        res_q     <= '0;
        row_out_q <= '0;
        col_out_q <= '0;
        valid_q   <= 1'b0;
      end
    end
  end

  assign mask_pixel_result  = res_q;
  assign mask_pixel_row_out = row_out_q;
  assign mask_pixel_col_out = col_out_q;
  assign mask_pixel_valid   = valid_q;
  assign frame_done         = done_q;
  assign busy               = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_mask_pixel_engine.sv
`default_nettype none
// ============================================================================
// tb_mask_pixel_engine : scoreboard bench for mask_pixel_engine on a small image
// Revision: 1.0
// ============================================================================
module tb_mask_pixel_engine;
  localparam int W = 10;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pix_in;
  logic        pix_valid;
  logic        pix_sof;
  logic [1:0]  mask_sel;
  logic [11:0] mask_pixel_result;
  logic [7:0]  mask_pixel_row_out;
  logic [8:0]  mask_pixel_col_out;
  logic        mask_pixel_valid;
  logic        frame_done;
  logic        busy;

  mask_pixel_engine #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .mask_sel(mask_sel), .mask_pixel_result(mask_pixel_result),
    .mask_pixel_row_out(mask_pixel_row_out), .mask_pixel_col_out(mask_pixel_col_out),
    .mask_pixel_valid(mask_pixel_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          row;
    int          col;
    logic [11:0] pix;
  } exp_t;

  exp_t        exp_q[$];
  int          fd_q[$];
  exp_t        mon_e;
  logic [11:0] img [H][W];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: filter rules evaluated directly on the stored image.
  function automatic logic [11:0] ref_pix(input logic [1:0] m, input int r, input int c);
    logic [11:0] res;
    int p[3][3];
    int v;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          p[dr][dc] = (int'(img[r+dr-1][c+dc-1]) >> (4*ch)) & 15;
      case (m)
        2'd0: v = p[1][1];
        2'd1: v = (p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1] + 2*p[1][2]
                 + p[2][0] + 2*p[2][1] + p[2][2]) / 16;
        2'd2: begin
          v = 5*p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
          if (v < 0)  v = 0;
          if (v > 15) v = 15;
        end
        default: v = 15 - p[1][1];
      endcase
      res[4*ch +: 4] = 4'(v);
    end
    return res;
  endfunction

  task automatic fill_flat(input logic [11:0] v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 12'($urandom);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_in    = 12'($urandom);
    mask_sel  = 2'($urandom);
  endtask

  // Sends a frame up to (stop_r, stop_c) exclusive; stall_r inserts a 10-cycle gap.
  task automatic send_frame(input logic [1:0] m, input int stop_r, input int stop_c,
                            input int gap_pct, input int stall_r);
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (r == stall_r && c == 4) repeat (10) idle_cycle();
        if (!(r == 0 && c == 0))
          while (int'($urandom_range(0, 99)) < gap_pct) idle_cycle();
        @(posedge clk); #1;
        pix_in    = img[r][c];
        pix_valid = 1'b1;
        pix_sof   = (r == 0 && c == 0);
        mask_sel  = (r == 0 && c == 0) ? m : 2'($urandom);
        if (r == 2 && c == 0) check("busy_mid_frame", int'(busy), 1);
        if (r >= 2 && c >= 2) begin
          e.cyc = cyc + 2;
          e.row = r - 1;
          e.col = c - 1;
          e.pix = ref_pix(m, r - 1, c - 1);
          exp_q.push_back(e);
        end
        if (r == H-1 && c == W-1) fd_q.push_back(cyc + 3);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_output: actual=none expected=row %0d col %0d at cycle %0d",
                 exp_q[0].row, exp_q[0].col, exp_q[0].cyc);
        mon_e = exp_q.pop_front();
      end
      if (mask_pixel_valid) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: actual=row %0d col %0d pix 0x%03h expected=no output (cycle %0d)",
                   mask_pixel_row_out, mask_pixel_col_out, mask_pixel_result, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", int'(mask_pixel_result), int'(mon_e.pix));
          check("row_out", int'(mask_pixel_row_out), mon_e.row);
          check("col_out", int'(mask_pixel_col_out), mon_e.col);
        end
      end else begin
        check("idle_outputs_zero",
              int'({mask_pixel_result, mask_pixel_row_out, mask_pixel_col_out}), 0);
      end
      while (fd_q.size() > 0 && fd_q[0] < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_frame_done: actual=none expected=cycle %0d", fd_q[0]);
        void'(fd_q.pop_front());
      end
      if (frame_done) begin
        if (fd_q.size() == 0 || fd_q[0] != cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame_done: actual=pulse at cycle %0d expected=none", cyc);
        end else begin
          check("frame_done_cycle", cyc, fd_q[0]);
          void'(fd_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rc;
    reset = 1'b1; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0; mask_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", int'(mask_pixel_result), 0);
    check("reset_row", int'(mask_pixel_row_out), 0);
    check("reset_col", int'(mask_pixel_col_out), 0);
    check("reset_valid", int'(mask_pixel_valid), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_busy", int'(busy), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Identity on a flat field, back-to-back pixels
    fill_flat(12'hABC);
    send_frame(2'd0, -1, -1, 0, -1);
    repeat (6) idle_cycle();
    check("busy_after_frame", int'(busy), 0);

    // Blur with a single bright pixel
    fill_flat(12'h888);
    img[5][5] = 12'hFFF;
    send_frame(2'd1, -1, -1, 0, -1);
    repeat (4) idle_cycle();

    // Sharpen with clamp-high and clamp-low neighbourhoods
    fill_rand();
    img[2][2] = 12'hF00; img[1][2] = 12'h000; img[3][2] = 12'h000;
    img[2][1] = 12'h000; img[2][3] = 12'h000;
    img[5][6] = 12'h000; img[4][6] = 12'hFFF; img[6][6] = 12'hFFF;
    img[5][5] = 12'hFFF; img[5][7] = 12'hFFF;
    send_frame(2'd2, -1, -1, 20, -1);
    repeat (4) idle_cycle();

    // Invert with mask_sel toggling mid-frame, then identity with a 10-cycle stall
    fill_rand();
    send_frame(2'd3, -1, -1, 25, -1);
    repeat (4) idle_cycle();
    fill_rand();
    send_frame(2'd0, -1, -1, 0, 3);
    repeat (4) idle_cycle();

    for (int k = 0; k < 4; k++) begin
      fill_rand();
      send_frame(2'(k), -1, -1, 35, -1);
      repeat (3) idle_cycle();
    end

    // Abandoned frame followed by a fresh SOF
    fill_rand();
    send_frame(2'd1, 4, 3, 10, -1);
    repeat (3) idle_cycle();
    fill_rand();
    send_frame(2'd2, -1, -1, 10, -1);
    repeat (4) idle_cycle();

    // Reset mid-RUN with a simultaneous SOF, then pixels without SOF
    fill_rand();
    send_frame(2'd0, 4, 3, 0, -1);
    @(posedge clk); #1;
    reset     = 1'b1;
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_in    = 12'($urandom);
    rc = cyc;
    while (exp_q.size() > 0 && exp_q[$].cyc > rc) void'(exp_q.pop_back());
    while (fd_q.size() > 0 && fd_q[$] > rc) void'(fd_q.pop_back());
    @(posedge clk); #1;
    check("post_reset_valid", int'(mask_pixel_valid), 0);
    check("post_reset_busy", int'(busy), 0);
    reset   = 1'b0;
    pix_sof = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
      pix_in    = 12'($urandom);
    end
    idle_cycle();
    repeat (4) idle_cycle();
    check("busy_ignored_pixels", int'(busy), 0);

    fill_rand();
    send_frame(2'd1, -1, -1, 15, -1);
    repeat (8) idle_cycle();
    check("scoreboard_drained", exp_q.size() + fd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
